mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access stage for the single-issue MIPS datapath, directly downstream of the control decoder. It consumes the decoder's 2-bit MemRead/Memwrite size codes together with the ALU-computed address and the rt value. It runs a req/ack transaction to a 32-bit, variable-latency data memory with byte-lane enables. It returns sign-extended load data plus a stall signal to hold the pipeline while the access is in flight.

## Interface
- TIMEOUT, 255: maximum ACCESS cycles without mem_ack before abort; must be ≥1.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- MemRead  in  2  load size: 00 none, 01 lb, 10 lh, 11 lw
- Memwrite  in  2  store size: 00 none, 01 sb, 10 sh, 11 sw
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rt)
- rdata_out  out  32  sign-extended load result
- done  out  1  one-cycle completion pulse
- busy  out  1  pipeline stall; high throughout ACCESS
- misaligned  out  1  alignment fault; valid with done
- timeout  out  1  no-ack abort; valid with done
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables; bit i = bits [8i+7:8i]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data; valid when mem_ack=1
- mem_ack  in  1  memory completion

## Operation
- Byte lanes are little-endian. Lane = addr[1:0]; lane 0 = bits [7:0].
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - busy=0, mem_req=0.
  - On start=1 with MemRead≠0 or Memwrite≠0: latch the size, direction, addr and wdata.
  - Both codes nonzero: the load executes and Memwrite is ignored.
  - start=1 with both codes 00: ignored; no transition.
- **Alignment check (at accept)**
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - Violation: go straight to DONE with misaligned=1; no memory access; rdata_out unchanged.
  - Otherwise go to ACCESS.
- **Byte enables**
  - byte: 4'b0001<<addr[1:0]
  - half: 0011 (addr[1]=0) or 1100 (addr[1]=1)
  - word: 1111
  - Same enables for loads and stores.
- **Store data**
  - sb: wdata[7:0] replicated ×4.
  - sh: wdata[15:0] replicated ×2.
  - sw: wdata unchanged.
- **ACCESS**
  - busy=1, mem_req=1.
  - mem_we, mem_addr, mem_be and mem_wdata are registered and stable for the whole state.
  - On mem_ack=1 at a clock edge:
    - Load: capture the selected lane/half of mem_rdata, sign-extend to 32 bits into rdata_out.
    - Store: rdata_out unchanged.
    - Go to DONE.
  - A cycle counter starts at 0 on entry and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT: drop mem_req, go to DONE with timeout=1, rdata_out unchanged.
- **DONE**
  - One cycle: done=1, busy=0, mem_req=0; misaligned/timeout as set.
  - Go to IDLE. start is ignored in DONE and ACCESS.
- mem_ack outside ACCESS is ignored.
- rdata_out holds its value until the next successful load.

## Timing
- Reset values (asynchronous on rst_n=0): all outputs 0, state IDLE, counter 0.
- Reset mid-ACCESS: mem_req falls immediately and the transaction is abandoned; no done pulse.
- Aligned access, start sampled at edge 0:
  - ACCESS from edge 0 to edge k, where edge k is the first edge with mem_ack=1.
  - DONE during the cycle after edge k.
  - Minimum: ack present in the first ACCESS cycle → done high in the 2nd cycle after start.
- Misaligned access: done high in the cycle after start.
- Timeout: TIMEOUT ACCESS cycles without ack, then one DONE cycle.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE, so the minimum issue interval is 3 cycles.
- mem_ack may stay high after completion; the unit leaves ACCESS on the first ack edge and does not re-issue.

## Test plan
- lw, addr=0x100, mem_rdata=0xDEADBEEF, ack after 3 wait cycles → mem_be=1111, mem_addr=0x100, busy high 4 cycles, done pulse, rdata_out=0xDEADBEEF.
- lb, addr=0x103, mem_rdata=0x80000000, immediate ack → mem_be=1000, rdata_out=0xFFFFFF80; then lh at 0x102 with mem_rdata=0x7FFF0000 → be=1100, rdata_out=0x00007FFF.
- sh, addr=0x206, wdata=0x1234ABCD → mem_we=1, be=1100, mem_wdata=0xABCDABCD, mem_addr=0x204; rdata_out unchanged.
- lw at 0x102 and sh at 0x001 → no mem_req, done and misaligned=1 in the cycle after start.
- lw with mem_ack never asserted, TIMEOUT=4 → mem_req high exactly 4 cycles, then done=1 and timeout=1.
- rst_n asserted low in the 2nd ACCESS cycle → mem_req/busy drop immediately, no done pulse; after release, sb at 0x001 (wdata=0xAA) → be=0010, mem_wdata=0xAAAAAAAA.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Data-memory access stage. Turns decoder load/store size codes,
//             the ALU address and rt into a req/ack transaction against a
//             32-bit byte-enabled memory. It returns sign-extended load data
//             and a stall while the access is in flight.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  Memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        busy,
  output logic        misaligned,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // Counter only has to reach TIMEOUT-1; the extra headroom keeps TIMEOUT=1 legal.
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  state_e        state_q, state_d;
  logic          is_load_q, is_load_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          misaligned_q, misaligned_d;
  logic          timeout_q, timeout_d;

  logic          acc_valid;
  logic          acc_load;
  logic [1:0]    acc_size;
  logic          acc_misal;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;

  // Decode the incoming request: a load wins when both size codes are nonzero.
  always_comb begin
    acc_load  = (MemRead != 2'b00);
    acc_valid = start && ((MemRead != 2'b00) || (Memwrite != 2'b00));
    acc_size  = acc_load ? MemRead : Memwrite;
    acc_misal = ((acc_size == SZ_HALF) && addr[0]) ||
                ((acc_size == 2'b11) && (addr[1:0] != 2'b00));
    case (acc_size)
      SZ_BYTE: begin
        acc_be    = 4'b0001 << addr[1:0];
        acc_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        acc_be    = addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{wdata[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wdata = wdata;
      end
    endcase
  end

  // Select the addressed lane/half of the returned word and sign-extend it.
  always_comb begin
    ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: ld_data = {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state and datapath update; fault flags live for the DONE cycle only.
  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    size_d       = size_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    misaligned_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_valid) begin
          is_load_d = acc_load;
          size_d    = acc_size;
          lane_d    = addr[1:0];
          cnt_d     = '0;
          if (acc_misal) begin
            // Faulting requests never touch the memory bus.
            state_d      = S_DONE;
            misaligned_d = 1'b1;
          end else begin
            state_d     = S_ACCESS;
            mem_we_d    = !acc_load;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = acc_be;
            mem_wdata_d = acc_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          if (is_load_q) begin
            rdata_d = ld_data;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      is_load_q    <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      cnt_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  // Status outputs decode straight from the state register so an async reset
  // drops the request and stall without waiting for a clock.
  always_comb begin
    busy       = (state_q == S_ACCESS);
    mem_req    = (state_q == S_ACCESS);
    done       = (state_q == S_DONE);
    misaligned = misaligned_q;
    timeout    = timeout_q;
    rdata_out  = rdata_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_be     = mem_be_q;
    mem_wdata  = mem_wdata_q;
  end

endmodule
`default_nettype wire
